// File: rtl/sample_capture.sv
// Frame capture at the end of the FIR test chain: stores one armed frame of
// signed samples (immediate or rising-zero-crossing start) and streams it out.
module sample_capture #(
  parameter int SAMP_WIDTH = 24,
  parameter int CAP_DEPTH  = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_arm,
  input  logic                  i_trig_mode,
  input  logic                  i_abort,
  input  logic                  i_samp_valid,
  input  logic [SAMP_WIDTH-1:0] i_samp,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_rd_valid,
  output logic [SAMP_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_last,
  input  logic                  i_rd_ready
);

  localparam int CAP_ADDR = $clog2(CAP_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_TRIG,
    ST_CAPTURE,
    ST_READOUT
  } state_t;

  state_t                state, state_nxt;
  logic [CAP_ADDR-1:0]   wr_ptr;
  logic                  prev_valid;
  logic                  prev_msb;

  // Readout pipeline: RAM output stage, output register and one skid entry.
  logic [CAP_ADDR:0]     rd_cnt;
  logic                  rd_pend;
  logic                  pend_last;
  logic [SAMP_WIDTH-1:0] ram_q;
  logic                  skid_valid;
  logic                  skid_last;
  logic [SAMP_WIDTH-1:0] skid_data;

  logic [SAMP_WIDTH-1:0] mem [CAP_DEPTH];

  logic                  trig_hit;
  logic                  cap_wr;
  logic                  ram_we;
  logic [CAP_ADDR-1:0]   ram_addr;
  logic                  xfer;
  logic                  last_xfer;
  logic [1:0]            occ;
  logic                  rd_issue;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_nxt = state;
    trig_hit  = (state == ST_WAIT_TRIG) && i_samp_valid && prev_valid &&
                prev_msb && !i_samp[SAMP_WIDTH-1];
    cap_wr    = (state == ST_CAPTURE) && i_samp_valid;
    ram_we    = !i_abort && (trig_hit || cap_wr);
    xfer      = o_rd_valid && i_rd_ready;
    last_xfer = xfer && o_rd_last;
    // Entries held after this cycle; a new read is only issued if its data
    // is guaranteed a slot when it lands next cycle.
    occ       = 2'(o_rd_valid) + 2'(skid_valid) + 2'(rd_pend) - 2'(xfer);
    rd_issue  = (state == ST_READOUT) && !i_abort && !rd_cnt[CAP_ADDR] &&
                (occ < 2'd2);
    if (state == ST_READOUT) ram_addr = rd_cnt[CAP_ADDR-1:0];
    else if (trig_hit)       ram_addr = '0;
    else                     ram_addr = wr_ptr;

    unique case (state)
      ST_IDLE:      if (i_arm) state_nxt = i_trig_mode ? ST_WAIT_TRIG : ST_CAPTURE;
      ST_WAIT_TRIG: if (trig_hit) state_nxt = ST_CAPTURE;
      ST_CAPTURE:   if (cap_wr && (&wr_ptr)) state_nxt = ST_READOUT;
      ST_READOUT:   if (last_xfer) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
    if (i_abort) state_nxt = ST_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments and the async
  // active-low reset so every register updates from pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      prev_valid <= 1'b0;
      prev_msb   <= 1'b0;
    end else if (i_abort || (state == ST_IDLE && i_arm)) begin
      wr_ptr     <= '0;
      prev_valid <= 1'b0;
    end else if (trig_hit) begin
      wr_ptr     <= CAP_ADDR'(1);
    end else if (cap_wr) begin
      wr_ptr     <= wr_ptr + 1'b1;
    end else if (state == ST_WAIT_TRIG && i_samp_valid) begin
      prev_valid <= 1'b1;
      prev_msb   <= i_samp[SAMP_WIDTH-1];
    end
  end

  // NOTE: the sample RAM has no reset; it is never read before being written
  // in the same frame, and a reset would prevent RAM inference.
  always_ff @(posedge i_clk) begin
    if (ram_we)   mem[ram_addr] <= i_samp;
    if (rd_issue) ram_q <= mem[ram_addr];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_cnt     <= '0;
      rd_pend    <= 1'b0;
      pend_last  <= 1'b0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
      skid_data  <= '0;
      o_rd_valid <= 1'b0;
      o_rd_last  <= 1'b0;
      o_rd_data  <= '0;
      o_done     <= 1'b0;
    end else begin
      o_done <= last_xfer && !i_abort;
      if (i_abort || state != ST_READOUT) begin
        rd_cnt     <= '0;
        rd_pend    <= 1'b0;
        skid_valid <= 1'b0;
        o_rd_valid <= 1'b0;
        o_rd_last  <= 1'b0;
      end else begin
        if (rd_issue) rd_cnt <= rd_cnt + 1'b1;
        rd_pend   <= rd_issue;
        pend_last <= rd_issue && (&rd_cnt[CAP_ADDR-1:0]);
        // Output register refills from skid first, then from the RAM stage,
        // so beat order is preserved across stalls.
        if (!o_rd_valid || xfer) begin
          if (skid_valid) begin
            o_rd_valid <= 1'b1;
            o_rd_data  <= skid_data;
            o_rd_last  <= skid_last;
            skid_valid <= rd_pend;
            skid_data  <= ram_q;
            skid_last  <= pend_last;
          end else if (rd_pend) begin
            o_rd_valid <= 1'b1;
            o_rd_data  <= ram_q;
            o_rd_last  <= pend_last;
          end else begin
            o_rd_valid <= 1'b0;
            o_rd_last  <= 1'b0;
          end
        end else if (rd_pend) begin
          skid_valid <= 1'b1;
          skid_data  <= ram_q;
          skid_last  <= pend_last;
        end
      end
    end
  end

  assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sample_capture.sv
// Directed-plus-random bench for sample_capture (CAP_DEPTH=16): frames are
// predicted from the list of strobed samples and compared beat by beat.
module tb_sample_capture;
  localparam int SW    = 24;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0, trig_mode = 1'b0, abort = 1'b0;
  logic          samp_valid = 1'b0, rd_ready = 1'b1;
  logic [SW-1:0] samp = '0;
  logic          busy, done, rd_valid, rd_last;
  logic [SW-1:0] rd_data;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  int            src_q[$];
  int            strobed_q[$];
  logic [SW-1:0] got_data[$];
  logic          got_last[$];
  int            got_cyc[$];
  int            done_cyc[$];

  sample_capture #(.SAMP_WIDTH(SW), .CAP_DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_arm        (arm),
    .i_trig_mode  (trig_mode),
    .i_abort      (abort),
    .i_samp_valid (samp_valid),
    .i_samp       (samp),
    .o_busy       (busy),
    .o_done       (done),
    .o_rd_valid   (rd_valid),
    .o_rd_data    (rd_data),
    .o_rd_last    (rd_last),
    .i_rd_ready   (rd_ready)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Beat collector and stall-stability monitor, sampled mid-cycle.
  logic          prev_stall = 1'b0;
  logic [SW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  always @(negedge clk) begin
    if (prev_stall && rst_n) begin
      check("stall_valid", rd_valid, 1);
      check("stall_data", rd_data, prev_data);
      check("stall_last", rd_last, prev_last);
    end
    prev_stall = rst_n && rd_valid && !rd_ready;
    prev_data  = rd_data;
    prev_last  = rd_last;
    if (rd_valid && rd_ready) begin
      got_data.push_back(rd_data);
      got_last.push_back(rd_last);
      got_cyc.push_back(cyc);
    end
    if (done) begin
      done_cyc.push_back(cyc);
      check("busy_at_done", busy, 0);
    end
  end

  task automatic clear_mon();
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
    done_cyc.delete();
    strobed_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arms, feeds src_q at one strobe every `gap` cycles, and runs until o_done.
  task automatic run(input bit mode, input int gap, input bit rand_ready,
                     input bit arm_with_samp, input bit glitch_arm);
    bit glitched_ro = 1'b0;
    clear_mon();
    tick();
    arm = 1'b1;
    trig_mode = mode;
    rd_ready = 1'b1;
    if (arm_with_samp) begin
      samp_valid = 1'b1;
      samp = SW'(src_q.pop_front());
    end
    for (int c = 1; c < 800; c++) begin
      tick();
      arm = 1'b0;
      samp_valid = 1'b0;
      if (done_cyc.size() > 0) break;
      if (glitch_arm && (c == 6 || (rd_valid && !glitched_ro))) begin
        arm = 1'b1;
        if (c != 6) glitched_ro = 1'b1;
      end
      if ((c % gap) == 0 && src_q.size() > 0) begin
        int v;
        v = src_q.pop_front();
        samp_valid = 1'b1;
        samp = SW'(v);
        strobed_q.push_back(v);
      end
      rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    rd_ready = 1'b1;
    src_q.delete();
    check("done_seen", done_cyc.size(), 1);
  endtask

  // Frame = first DEPTH strobes after arm (mode 0) or DEPTH strobes starting
  // at the first negative-to-non-negative step (mode 1).
  task automatic verify(input string name, input bit mode, input bit back_to_back);
    int start = 0;
    if (mode) begin
      start = -1;
      for (int i = 1; i < strobed_q.size(); i++)
        if (strobed_q[i-1] < 0 && strobed_q[i] >= 0) begin
          start = i;
          break;
        end
    end
    check({name, "_beats"}, got_data.size(), DEPTH);
    for (int k = 0; k < DEPTH && k < got_data.size(); k++) begin
      logic [SW-1:0] ev;
      int idx;
      idx = start + k;
      ev = (start >= 0 && idx < strobed_q.size()) ? SW'(strobed_q[idx]) : '1;
      check({name, "_data"}, got_data[k], ev);
      check({name, "_last"}, got_last[k], (k == DEPTH - 1));
      if (back_to_back) check({name, "_gap"}, got_cyc[k] - got_cyc[0], k);
    end
    if (done_cyc.size() > 0 && got_cyc.size() > 0)
      check({name, "_done_time"}, done_cyc[0], got_cyc[got_cyc.size()-1] + 1);
    check({name, "_busy_after"}, busy, 0);
  endtask

  initial begin
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_last", rd_last, 0);
    check("rst_data", rd_data, 0);
    tick();
    rst_n = 1'b1;

    // Mode 0 ramp, slow strobes; later ramp samples land during readout.
    for (int i = 0; i < 32; i++) src_q.push_back(i);
    run(0, 4, 0, 0, 0);
    verify("m0_ramp", 0, 1);

    // Mode 1: crossing onto zero.
    for (int i = -3; i <= 20; i++) src_q.push_back(i);
    run(1, 1, 0, 0, 0);
    verify("m1_zero", 1, 1);

    // Mode 1: crossing from -1 to +5.
    src_q.push_back(-1);
    for (int i = 5; i <= 25; i++) src_q.push_back(i);
    run(1, 2, 0, 0, 0);
    verify("m1_jump", 1, 1);

    // Leave a negative prev sample behind via abort, then a first +2 must not trigger.
    tick();
    arm = 1'b1;
    trig_mode = 1'b1;
    tick();
    arm = 1'b0;
    samp_valid = 1'b1;
    samp = SW'(-7);
    tick();
    samp_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("wt_abort_busy", busy, 0);
    src_q = '{2, 3, -1};
    for (int i = 9; i <= 30; i++) src_q.push_back(i);
    run(1, 1, 0, 0, 0);
    verify("m1_first", 1, 1);

    // Backpressure with random data.
    for (int i = 0; i < 20; i++) src_q.push_back(int'($urandom_range(0, 4000)) - 2000);
    run(0, 1, 1, 0, 0);
    verify("bp", 0, 0);

    // Arm during CAPTURE and READOUT, plus a strobe on the arm cycle.
    for (int i = 500; i < 530; i++) src_q.push_back(i);
    run(0, 2, 0, 1, 1);
    verify("arm_glitch", 0, 1);

    // Abort mid-capture at write pointer 7, then a fresh frame.
    clear_mon();
    tick();
    arm = 1'b1;
    trig_mode = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      arm = 1'b0;
      samp_valid = 1'b1;
      samp = SW'(100 + i);
    end
    tick();
    samp_valid = 1'b1;
    samp = SW'(107);
    abort = 1'b1;
    tick();
    samp_valid = 1'b0;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", rd_valid, 0);
    repeat (40) tick();
    check("abort_beats", got_data.size(), 0);
    check("abort_done", done_cyc.size(), 0);
    for (int i = 0; i < 16; i++) src_q.push_back(1000 - 37 * i);
    run(0, 1, 0, 0, 0);
    verify("rearm", 0, 1);

    // Random mode 1 with backpressure; a guaranteed crossing is appended.
    for (int i = 0; i < 40; i++) src_q.push_back(int'($urandom_range(0, 200)) - 100);
    src_q.push_back(-1);
    for (int i = 1; i <= 16; i++) src_q.push_back(i);
    run(1, 2, 1, 0, 0);
    verify("m1_rand", 1, 0);

    // Reset while stalled in READOUT.
    clear_mon();
    tick();
    arm = 1'b1;
    trig_mode = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      arm = 1'b0;
      rd_ready = 1'b0;
      samp_valid = 1'b1;
      samp = SW'(i + 1);
    end
    tick();
    samp_valid = 1'b0;
    for (int i = 0; i < 20 && !rd_valid; i++) tick();
    check("ro_reached", rd_valid, 1);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_valid", rd_valid, 0);
    check("arst_last", rd_last, 0);
    check("arst_data", rd_data, 0);
    tick();
    rst_n = 1'b1;
    rd_ready = 1'b1;
    clear_mon();
    for (int i = 0; i < 30; i++) begin
      tick();
      samp_valid = (i % 2 == 0);
      samp = SW'(i);
    end
    tick();
    samp_valid = 1'b0;
    check("post_rst_busy", busy, 0);
    check("post_rst_beats", got_data.size(), 0);
    check("post_rst_done", done_cyc.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sample_capture.md
# sample_capture

Capture block at the far end of the FIR test chain. It stores one armed frame of CAP_DEPTH signed samples from a sample-rate-strobed stream into internal RAM, then streams the frame out over a valid/ready port for host or debug readout. Capture can start immediately on arm or on the first rising zero crossing, which gives phase-aligned frames of sine and filtered-sine data.

## Interface
- SAMP_WIDTH, 24, sample width, two's complement
- CAP_DEPTH, 1024, frame length in samples; must be a power of two ≥ 4; CAP_ADDR = $clog2(CAP_DEPTH)
- i_clk  input  1  clock
- i_rst_n  input  1  reset, asynchronous, active-low
- i_arm  input  1  start pulse; honored only in IDLE
- i_trig_mode  input  1  0 = capture immediately, 1 = capture from rising zero crossing; sampled with i_arm
- i_abort  input  1  return to IDLE from any state
- i_samp_valid  input  1  sample strobe, one cycle per sample
- i_samp  input  SAMP_WIDTH  sample, valid when i_samp_valid=1
- o_busy  output  1  state != IDLE
- o_done  output  1  one-cycle pulse after the last readout handshake
- o_rd_valid  output  1  readout beat valid
- o_rd_data  output  SAMP_WIDTH  readout sample
- o_rd_last  output  1  high on beat CAP_DEPTH-1
- i_rd_ready  input  1  readout sink ready

## Operation
- FSM states: IDLE, WAIT_TRIG, CAPTURE, READOUT.
- IDLE, i_arm=1: latch the mode. Mode 0 goes to CAPTURE. Mode 1 goes to WAIT_TRIG. wr_ptr=0. The prev_valid flag is cleared.
- i_samp_valid in the same cycle as i_arm is not captured.
- WAIT_TRIG, on each i_samp_valid:
  - if prev_valid=1, prev MSB=1 and the current MSB=0, write the current sample to address 0, set wr_ptr=1 and go to CAPTURE;
  - in every case, store the current sample as prev and set prev_valid=1.
  - Zero counts as non-negative.
  - The first sample after arm can never trigger.
- CAPTURE, on each i_samp_valid: write i_samp at wr_ptr and increment wr_ptr.
  - The write at address CAP_DEPTH-1 moves to READOUT.
  - No wrap; exactly CAP_DEPTH samples per frame.
- READOUT: emit addresses 0..CAP_DEPTH-1 in order.
  - A beat transfers when o_rd_valid & i_rd_ready.
  - o_rd_last=1 only on the beat for address CAP_DEPTH-1.
  - After the last transfer: go to IDLE and pulse o_done for one cycle.
  - i_samp_valid is ignored in READOUT.
- Storage is synchronous-read single-port RAM, CAP_DEPTH x SAMP_WIDTH. Writes happen only in CAPTURE/WAIT_TRIG, reads only in READOUT, so there are no port conflicts.
- i_abort=1, any state: next state IDLE. o_rd_valid drops the next cycle, and o_done does not pulse. i_abort has priority over i_arm, trigger and handshake events in the same cycle. RAM contents are undefined after abort.
- i_arm outside IDLE is ignored, with no effect on pointers.
- Reset values:
  - state IDLE;
  - all pointers 0;
  - prev_valid 0;
  - o_busy, o_done, o_rd_valid and o_rd_last 0;
  - o_rd_data 0.

## Timing
- o_busy rises the cycle after i_arm. It falls on the same cycle o_done is high.
- Capture latency: the sample strobed at cycle t is in RAM by cycle t+1. The last capture write at cycle t means state=READOUT at t+1.
- First o_rd_valid no later than 2 cycles after entering READOUT, to allow for the RAM read latency.
- Throughput: with i_rd_ready held high, one beat per cycle with no bubbles. Use a prefetch/skid register so a stall never loses or repeats data.
- Stall rule: while o_rd_valid=1 and i_rd_ready=0, o_rd_data, o_rd_last and o_rd_valid hold stable.
- o_done is asserted in the cycle after the last transfer. The block accepts i_arm again in the same cycle o_done is high, because the state is already IDLE.
- Reset asserted mid-operation clears everything asynchronously. No o_done is issued.

## Test plan
- Mode 0, CAP_DEPTH=16, i_samp = ramp 0..31 at one sample every 4 cycles, arm before the first strobe, i_rd_ready=1:
  - readout is 0..15 on 16 consecutive cycles;
  - o_rd_last on the beat carrying 15;
  - o_done one cycle after it.
- Mode 1, samples -3,-2,-1,0,1,…: capture starts at 0, so the frame is 0,1,…,15. Repeat with -1,+5: the frame starts at 5. A first sample of +2 after arm does not trigger.
- Backpressure: toggle i_rd_ready pseudo-randomly during readout. All 16 beats arrive in order with no duplicates, and data stays stable during every stall.
- i_arm pulsed during CAPTURE and during READOUT: no effect, and the frame content is unchanged. i_arm and i_samp_valid in the same cycle in IDLE: that sample is excluded and the frame starts with the next one.
- i_abort mid-CAPTURE at wr_ptr=7: IDLE next cycle, o_busy=0, no o_done. A re-arm then captures a full fresh frame correctly.
- i_rst_n pulsed low mid-READOUT, while stalled:
  - every output is 0 immediately;
  - after release, o_busy=0 and no beats appear until the next arm.
